// File: rtl/mouse_pkg.sv
// Shared PS/2 mouse definitions: receiver state encoding, error-code bit
// positions and the default inter-edge timeout.
package mouse_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DATA   = 3'd1,
    ST_PARITY = 3'd2,
    ST_STOP   = 3'd3,
    ST_DONE   = 3'd4
  } rx_state_t;

  localparam int unsigned ERR_PARITY_BIT = 0;
  localparam int unsigned ERR_STOP_BIT   = 1;

  // 500 us between mouse-clock falling edges at 100 MHz
  localparam int unsigned TIMEOUT_CYCLES_DEF = 50000;

endpackage

// File: rtl/mouse_line_sync.sv
// PS/2 line conditioning: 2-FF synchronizers, falling-edge detect on the mouse
// clock, optional glitch filter enabled by MOUSE_RX_CLK_FILTER_EN.
module mouse_line_sync #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic CLK,
  input  logic RESET,
  input  logic CLK_MOUSE_IN,
  input  logic DATA_MOUSE_IN,
  output logic data_sync,
  output logic clk_fall
);

  logic [1:0] clk_sync;
  logic [1:0] dat_sync;
  logic       clk_line;
  logic       clk_prev;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      clk_sync <= '1;
      dat_sync <= '1;
    end else begin
      clk_sync <= {clk_sync[0], CLK_MOUSE_IN};
      dat_sync <= {dat_sync[0], DATA_MOUSE_IN};
    end
  end

`ifdef MOUSE_RX_CLK_FILTER_EN
  localparam int unsigned CW = $clog2(FILTER_LEN + 1);

  logic [CW-1:0] flt_cnt;
  logic          clk_filt;

  // Filtered level follows the synced clock only after FILTER_LEN
  // consecutive samples disagreeing with the current filtered level.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      flt_cnt  <= '0;
      clk_filt <= 1'b1;
    end else if (clk_sync[1] == clk_filt) begin
      flt_cnt <= '0;
    end else if (flt_cnt == CW'(FILTER_LEN - 1)) begin
      clk_filt <= clk_sync[1];
      flt_cnt  <= '0;
    end else begin
      flt_cnt <= flt_cnt + 1'b1;
    end
  end

  assign clk_line = clk_filt;
`else
  logic unused_filter_len;
  assign unused_filter_len = (FILTER_LEN == 0);
  assign clk_line = clk_sync[1];
`endif

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) clk_prev <= 1'b1;
    else        clk_prev <= clk_line;
  end

  assign clk_fall  = clk_prev & ~clk_line;
  assign data_sync = dat_sync[1];

endmodule

// File: rtl/mouse_receiver.sv
// PS/2 device-to-host frame receiver (start, 8 data LSB first, odd parity,
// stop). Optional clock glitch filter: MOUSE_RX_CLK_FILTER_EN.
module mouse_receiver
  import mouse_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned FILTER_LEN     = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CLK_MOUSE_IN,
  input  logic       DATA_MOUSE_IN,
  input  logic       READ_ENABLE,
  output logic [7:0] BYTE_READ,
  output logic [1:0] BYTE_ERROR_CODE,
  output logic       BYTE_READY
);

  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);

  logic data_sync;
  logic clk_fall;

  mouse_line_sync #(
    .FILTER_LEN(FILTER_LEN)
  ) u_line_sync (
    .CLK          (CLK),
    .RESET        (RESET),
    .CLK_MOUSE_IN (CLK_MOUSE_IN),
    .DATA_MOUSE_IN(DATA_MOUSE_IN),
    .data_sync    (data_sync),
    .clk_fall     (clk_fall)
  );

  rx_state_t   state, state_d;
  logic [2:0]  bit_cnt, bit_cnt_d;
  logic [15:0] tcnt, tcnt_d;
  logic [7:0]  shift, shift_d;
  logic        par_bit, par_d;
  logic [7:0]  byte_d;
  logic [1:0]  err_d;
  logic        ready_d;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state           <= ST_IDLE;
      bit_cnt         <= '0;
      tcnt            <= '0;
      shift           <= '0;
      par_bit         <= 1'b0;
      BYTE_READ       <= '0;
      BYTE_ERROR_CODE <= '0;
      BYTE_READY      <= 1'b0;
    end else begin
      state           <= state_d;
      bit_cnt         <= bit_cnt_d;
      tcnt            <= tcnt_d;
      shift           <= shift_d;
      par_bit         <= par_d;
      BYTE_READ       <= byte_d;
      BYTE_ERROR_CODE <= err_d;
      BYTE_READY      <= ready_d;
    end
  end

  // The outputs are loaded on the stop-bit edge so that the registered
  // BYTE_READY is high exactly during the single DONE cycle.
  always_comb begin
    state_d   = state;
    bit_cnt_d = bit_cnt;
    tcnt_d    = tcnt;
    shift_d   = shift;
    par_d     = par_bit;
    byte_d    = BYTE_READ;
    err_d     = BYTE_ERROR_CODE;
    ready_d   = 1'b0;

    unique case (state)
      ST_IDLE: begin
        tcnt_d = '0;
        if (clk_fall && !data_sync && READ_ENABLE) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end

      ST_DATA, ST_PARITY, ST_STOP: begin
        if (clk_fall) begin
          tcnt_d = '0;
          case (state)
            ST_DATA: begin
              shift_d[bit_cnt] = data_sync;
              bit_cnt_d        = bit_cnt + 1'b1;
              if (bit_cnt == 3'd7) state_d = ST_PARITY;
            end
            ST_PARITY: begin
              par_d   = data_sync;
              state_d = ST_STOP;
            end
            default: begin
              byte_d                = shift;
              err_d[ERR_PARITY_BIT] = ~(^shift ^ par_bit);
              err_d[ERR_STOP_BIT]   = ~data_sync;
              ready_d               = 1'b1;
              state_d               = ST_DONE;
            end
          endcase
        end else if (tcnt >= TO_LIMIT) begin
          state_d = ST_IDLE;
          tcnt_d  = '0;
        end else if (tcnt != '1) begin
          tcnt_d = tcnt + 1'b1;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mouse_receiver.sv
// Directed bench for mouse_receiver with a shortened timeout; the glitch test
// is included when MOUSE_RX_CLK_FILTER_EN is defined.
module tb_mouse_receiver;

  localparam int unsigned TO = 200;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       read_en = 1'b1;
  logic [7:0] byte_read;
  logic [1:0] err_code;
  logic       byte_ready;

  int errors = 0;
  int checks = 0;
  int ready_cnt = 0;
  int base;

  mouse_receiver #(
    .TIMEOUT_CYCLES(TO),
    .FILTER_LEN    (8)
  ) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .CLK_MOUSE_IN   (ps2_clk),
    .DATA_MOUSE_IN  (ps2_dat),
    .READ_ENABLE    (read_en),
    .BYTE_READ      (byte_read),
    .BYTE_ERROR_CODE(err_code),
    .BYTE_READY     (byte_ready)
  );

  always #5 CLK = ~CLK;

  // Counts cycles with BYTE_READY high; a clean strobe adds exactly one.
  always @(negedge CLK) if (byte_ready) ready_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic par, input logic stp);
    return {stp, par, d, 1'b0};
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Sends the first nbits of a frame, 40 CLK cycles per PS/2 bit.
  task automatic send_bits(input logic [10:0] frame, input int nbits, input bit drop_re);
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = frame[i];
      if (drop_re && i == 1) read_en = 1'b0;
      wait_cyc(10);
      ps2_clk = 1'b0;
      wait_cyc(20);
      ps2_clk = 1'b1;
      wait_cyc(10);
    end
    ps2_dat = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
    send_bits(mk_frame(d, par, stp), 11, 1'b0);
    wait_cyc(5);
  endtask

  initial begin
    wait_cyc(3);
    #1;
    check("rst_byte", {24'd0, byte_read}, 32'h00);
    check("rst_err", {30'd0, err_code}, 32'h0);
    check("rst_ready", {31'd0, byte_ready}, 32'h0);
    RESET = 1'b1;
    wait_cyc(5);

    // 0xFA: six ones -> parity 1
    base = ready_cnt;
    send_frame(8'hFA, 1'b1, 1'b1);
    check("fa_strobe", ready_cnt - base, 1);
    check("fa_byte", {24'd0, byte_read}, 32'hFA);
    check("fa_err", {30'd0, err_code}, 32'h0);

    // 0xF4: five ones -> correct parity 0, forced to 1
    base = ready_cnt;
    send_frame(8'hF4, 1'b1, 1'b1);
    check("f4_strobe", ready_cnt - base, 1);
    check("f4_byte", {24'd0, byte_read}, 32'hF4);
    check("f4_err", {30'd0, err_code}, 32'h1);

    base = ready_cnt;
    send_frame(8'h00, 1'b1, 1'b0);
    check("stop_strobe", ready_cnt - base, 1);
    check("stop_byte", {24'd0, byte_read}, 32'h00);
    check("stop_err", {30'd0, err_code}, 32'h2);

    // 0x55 stalls after bit 3: start + 4 data bits, then the clock idles
    base = ready_cnt;
    send_bits(mk_frame(8'h55, 1'b1, 1'b1), 5, 1'b0);
    wait_cyc(TO + 10);
    check("to_strobe", ready_cnt - base, 0);
    check("to_byte", {24'd0, byte_read}, 32'h00);
    check("to_err", {30'd0, err_code}, 32'h2);

    // 0x0A: two ones -> parity 1
    base = ready_cnt;
    send_frame(8'h0A, 1'b1, 1'b1);
    check("0a_strobe", ready_cnt - base, 1);
    check("0a_byte", {24'd0, byte_read}, 32'h0A);
    check("0a_err", {30'd0, err_code}, 32'h0);

    read_en = 1'b0;
    base = ready_cnt;
    send_frame(8'h33, 1'b1, 1'b1);
    check("re0_strobe", ready_cnt - base, 0);
    check("re0_byte", {24'd0, byte_read}, 32'h0A);

    // 0x33: four ones -> parity 1; READ_ENABLE drops after the start bit
    read_en = 1'b1;
    base = ready_cnt;
    send_bits(mk_frame(8'h33, 1'b1, 1'b1), 11, 1'b1);
    wait_cyc(5);
    check("re_drop_strobe", ready_cnt - base, 1);
    check("re_drop_byte", {24'd0, byte_read}, 32'h33);
    check("re_drop_err", {30'd0, err_code}, 32'h0);
    read_en = 1'b1;

    // Reset during bit 5 of a 0x77 frame (start + bits 0..4 already sent)
    base = ready_cnt;
    send_bits(mk_frame(8'h77, 1'b1, 1'b1), 6, 1'b0);
    ps2_dat = 1'b1;
    wait_cyc(5);
    RESET = 1'b0;
    #1;
    check("mrst_byte", {24'd0, byte_read}, 32'h00);
    check("mrst_err", {30'd0, err_code}, 32'h0);
    check("mrst_ready", {31'd0, byte_ready}, 32'h0);
    wait_cyc(3);
    RESET = 1'b1;
    wait_cyc(5);
    check("mrst_strobe", ready_cnt - base, 0);

    // 0xAA: four ones -> parity 1
    base = ready_cnt;
    send_frame(8'hAA, 1'b1, 1'b1);
    check("aa_strobe", ready_cnt - base, 1);
    check("aa_byte", {24'd0, byte_read}, 32'hAA);
    check("aa_err", {30'd0, err_code}, 32'h0);

`ifdef MOUSE_RX_CLK_FILTER_EN
    // 3-cycle low clock glitch with data low must not start a frame
    base = ready_cnt;
    ps2_dat = 1'b0;
    wait_cyc(5);
    ps2_clk = 1'b0;
    wait_cyc(3);
    ps2_clk = 1'b1;
    wait_cyc(20);
    ps2_dat = 1'b1;
    wait_cyc(10);
    send_frame(8'hFA, 1'b1, 1'b1);
    check("flt_strobe", ready_cnt - base, 1);
    check("flt_byte", {24'd0, byte_read}, 32'hFA);
    check("flt_err", {30'd0, err_code}, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
